// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler sharing one overlapping-pattern detector across NCH serial streams.
// Ports: clk/rst (sync, active-high); req/din/clr per channel in; gnt (comb one-hot grant),
//        flag/flag_ch (registered match pulse + channel), match_cnt (registered saturating total).
module seq_det_sched #(
  parameter int              NCH     = 4,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1010,
  parameter int              CW      = 8,
  localparam int             CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   din,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   gnt,
  output logic             flag,
  output logic [CHW-1:0]   flag_ch,
  output logic [CW-1:0]    match_cnt
);

  localparam int            FW       = $clog2(PLEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PLEN - 1);

  // Saved per-channel detector context
  logic [PLEN-2:0] hist_q [NCH];
  logic [PLEN-2:0] hist_d [NCH];
  logic [FW-1:0]   fill_q [NCH];
  logic [FW-1:0]   fill_d [NCH];

  logic [CHW-1:0]  ptr_q, ptr_d;
  logic            flag_q, flag_d;
  logic [CHW-1:0]  flag_ch_q, flag_ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NCH-1:0]  elig;
  logic [NCH-1:0]  gnt_vec;
  logic [CHW-1:0]  gnt_idx;
  logic [CHW-1:0]  cand;
  logic            gnt_any;
  logic [PLEN-1:0] next_bits;
  logic            match;

  // Round-robin arbiter: first eligible index scanning from ptr upward, wrapping.
  // A cleared channel is never eligible, so its presented bit is dropped.
  always_comb begin
    elig    = req & ~clr;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = CHW'((int'(ptr_q) + i) % NCH);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vec = gnt_any ? (NCH'(1) << gnt_idx) : '0;
  end

  assign gnt = gnt_vec;

  // Shared detector: newest bit appended below the granted channel's history
  assign next_bits = {hist_q[gnt_idx], din[gnt_idx]};
  assign match     = gnt_any && (fill_q[gnt_idx] == FILL_MAX) && (next_bits == PATTERN);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hist_d[i] = hist_q[i];
      fill_d[i] = fill_q[i];
      if (clr[i]) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
      end else if (gnt_vec[i]) begin
        hist_d[i] = next_bits[PLEN-2:0];
        fill_d[i] = (fill_q[i] == FILL_MAX) ? FILL_MAX : fill_q[i] + 1'b1;
      end
    end

    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    flag_d    = match;
    flag_ch_d = match ? gnt_idx : '0;

    cnt_d = cnt_q;
    if (match && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
      ptr_q     <= '0;
      flag_q    <= 1'b0;
      flag_ch_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= hist_d[i];
        fill_q[i] <= fill_d[i];
      end
      ptr_q     <= ptr_d;
      flag_q    <= flag_d;
      flag_ch_q <= flag_ch_d;
      cnt_q     <= cnt_d;
    end
  end

  assign flag      = flag_q;
  assign flag_ch   = flag_ch_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: directed self-checking bench for seq_det_sched (NCH=4, PLEN=4, PATTERN=1010, CW=3).
// Ports: drives clk/rst/req/din/clr, observes gnt/flag/flag_ch/match_cnt.
// Inputs change 1ns after the rising edge; outputs are sampled just before / 1ns after it.
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] clr;
  logic [3:0] gnt;
  logic       flag;
  logic [1:0] flag_ch;
  logic [2:0] match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  seq_det_sched #(
    .NCH    (4),
    .PLEN   (4),
    .PATTERN(4'b1010),
    .CW     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .clr      (clr),
    .gnt      (gnt),
    .flag     (flag),
    .flag_ch  (flag_ch),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic [3:0] c);
    req = r;
    din = d;
    clr = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000);
    tick();
    rst = 1'b0;
  endtask

  // Present one bit on ch0 alone, check the grant, then the registered flag
  task automatic send0(input logic b, input logic exp_flag, input string tag);
    drive(4'b0001, {3'b000, b}, 4'b0000);
    chk({tag, ".gnt"}, gnt, 1);
    tick();
    chk({tag, ".flag"}, flag, exp_flag);
    chk({tag, ".flag_ch"}, flag_ch, 0);
  endtask

  int sent [4];
  int m;

  initial begin
    rst = 1'b1;
    req = '0;
    din = '0;
    clr = '0;

    // Reset: two cycles high, then idle
    tick();
    tick();
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000);
    chk("rst.gnt", gnt, 0);
    tick();
    chk("rst.flag", flag, 0);
    chk("rst.flag_ch", flag_ch, 0);
    chk("rst.cnt", match_cnt, 0);
    chk("rst.gnt_idle", gnt, 0);

    // Single channel 101010: matches on 4th and 6th bits
    send0(1'b1, 1'b0, "single0");
    send0(1'b0, 1'b0, "single1");
    send0(1'b1, 1'b0, "single2");
    send0(1'b0, 1'b1, "single3");
    send0(1'b1, 1'b0, "single4");
    send0(1'b0, 1'b1, "single5");
    chk("single.cnt", match_cnt, 2);

    // Fair rotation: all four request, each sees its own 1,0,1,0
    do_reset();
    for (int k = 0; k < 4; k++) sent[k] = 0;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] d;
      for (int k = 0; k < 4; k++) d[k] = (sent[k] % 2 == 0);
      drive(4'b1111, d, 4'b0000);
      chk($sformatf("rot%0d.gnt", c), gnt, 1 << (c % 4));
      sent[c % 4]++;
      tick();
      chk($sformatf("rot%0d.flag", c), flag, (c >= 12) ? 1 : 0);
      chk($sformatf("rot%0d.flag_ch", c), flag_ch, (c >= 12) ? (c % 4) : 0);
    end
    chk("rot.cnt", match_cnt, 4);

    // Pointer skip: grant ch1 moves ptr to 2, then req=0011 wraps to ch0, then ch1
    drive(4'b0010, 4'b0000, 4'b0000);
    chk("skip.pre_gnt", gnt, 2);
    tick();
    drive(4'b0011, 4'b0000, 4'b0000);
    chk("skip.ptr2_gnt", gnt, 1);
    tick();
    drive(4'b0011, 4'b0000, 4'b0000);
    chk("skip.ptr1_gnt", gnt, 2);
    tick();

    // Clear mid-pattern: 1,0,1 then clr drops the bit and context, then 0 gives no match
    do_reset();
    send0(1'b1, 1'b0, "clr0");
    send0(1'b0, 1'b0, "clr1");
    drive(4'b0001, 4'b0001, 4'b0010);   // clr on another channel leaves ch0's grant alone
    chk("clr.other_gnt", gnt, 1);
    tick();
    drive(4'b0001, 4'b0000, 4'b0001);
    chk("clr.self_gnt", gnt, 0);
    tick();
    chk("clr.self_flag", flag, 0);
    send0(1'b0, 1'b0, "clr_after");
    chk("clr.cnt", match_cnt, 0);

    // Reset mid-pattern: 1,0,1, rst, then 0 must not match; 1,0,1,0 then does
    do_reset();
    send0(1'b1, 1'b0, "rmid0");
    send0(1'b0, 1'b0, "rmid1");
    send0(1'b1, 1'b0, "rmid2");
    rst = 1'b1;
    drive(4'b0001, 4'b0000, 4'b0000);
    tick();
    rst = 1'b0;
    chk("rmid.rst_flag", flag, 0);
    send0(1'b0, 1'b0, "rmid3");
    send0(1'b1, 1'b0, "rmid4");
    send0(1'b0, 1'b0, "rmid5");
    send0(1'b1, 1'b0, "rmid6");
    send0(1'b0, 1'b1, "rmid7");
    chk("rmid.cnt", match_cnt, 1);

    // Saturation: 22 bits of 1010... give 10 matches; 3-bit counter holds at 7
    do_reset();
    m = 0;
    for (int j = 0; j < 22; j++) begin
      logic ef;
      ef = (j >= 3) && (j % 2 == 1);
      if (ef) m++;
      send0((j % 2 == 0), ef, $sformatf("sat%0d", j));
      chk($sformatf("sat%0d.cnt", j), match_cnt, (m > 7) ? 7 : m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that shares one pattern-detection datapath among NCH serial bit streams. Each cycle it grants at most one requesting channel and shifts that channel's bit into the channel's own saved history context. It reports an overlapping-pattern match with the channel number one cycle later. It sits between several serial sources and the sequence-detect flag consumers, replacing NCH separate detector instances.

## Interface
- NCH, 4: number of serial channels (2..8).
- PLEN, 4: pattern length in bits (2..8).
- PATTERN, 4'b1010: PLEN-bit target. MSB is the oldest bit, LSB is the newest.
- CW, 8: width of the match counter.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NCH  req[i]=1: channel i presents a valid bit on din[i].
- din  in  NCH  serial data bit per channel.
- clr  in  NCH  clr[i]=1: discard channel i context this cycle.
- gnt  out  NCH  one-hot or zero, combinational from req, clr and ptr. Bit consumed when req[i]&gnt[i].
- flag  out  1  registered; match completed in previous cycle.
- flag_ch  out  ceil(log2 NCH)  registered; channel of the match, valid when flag=1, else 0.
- match_cnt  out  CW  registered total matches since reset, saturating.

## Operation
- Per-channel context: hist[i] (PLEN-1 bits) and fill[i] (0..PLEN-1, saturating), which counts bits received.
- Round-robin pointer ptr (0..NCH-1).
- Eligible set: e = req & ~clr. gnt is one-hot on the first eligible index scanning ptr, ptr+1, … (mod NCH). gnt=0 when e=0.
- On a grant to channel k:
  - next = {hist[k], din[k]} (PLEN bits).
  - hist[k] <= next[PLEN-2:0].
  - fill[k] <= min(fill[k]+1, PLEN-1).
  - ptr <= (k+1) mod NCH.
- Match when a grant occurs, fill[k]==PLEN-1 (before update) and next==PATTERN. Then flag<=1, flag_ch<=k, and match_cnt<=match_cnt+1 (held at 2^CW-1 once reached).
- Otherwise flag<=0 and flag_ch<=0.
- Overlapping matches count. With PATTERN 1010, the input 101010 gives two matches.
- With no grant: ptr, all contexts and match_cnt hold.
- clr[i]=1 sets hist[i]<=0 and fill[i]<=0. Channel i is not granted that cycle, so its bit is dropped and the source must re-present it. clr on non-granted channels is independent of the grant to channel k.
- Contexts of non-granted channels never change, except through clr.

## Timing
- Reset values, one cycle after rst sampled high:
  - gnt=0 until the next eligible request.
  - flag=0, flag_ch=0, match_cnt=0.
  - ptr=0, all hist=0, all fill=0.
- rst has priority over every other input. Assertion mid-pattern discards all partial contexts. The first match after reset needs PLEN fresh bits on that channel.
- gnt is valid in the same cycle as req, with no registered handshake delay. A source holds req/din until it sees gnt[i]=1 at a rising edge.
- Latency is 1 cycle: a matching bit consumed at edge n shows flag=1 during cycle n+1.
- Throughput is one bit per cycle in aggregate. With all NCH requesting continuously, each channel gets one grant every NCH cycles.
- flag can pulse on consecutive cycles for different channels. It is never held longer than one cycle per match.

## Test plan
- **Reset:** rst=1 for 2 cycles, then rst=0 with req=0 → gnt=0, flag=0, flag_ch=0, match_cnt=0.
- **Single channel:** req=0001 every cycle, din[0]=1,0,1,0,1,0.
  - gnt=0001 every cycle.
  - flag=1 with flag_ch=0 in the cycles after the 4th and 6th bits.
  - match_cnt=2.
- **Fair rotation and context isolation:** req=1111 continuously, with each channel's own bits being 1,0,1,0.
  - gnt=0001, 0010, 0100, 1000, repeating.
  - Interleaving must not cause a match before each channel's 4th bit.
  - Flags appear on 4 consecutive cycles with flag_ch=0,1,2,3, and match_cnt=4.
- **Pointer skip:** ptr=2 with req=0011 → gnt=0001. Next cycle ptr=1 with req=0011 → gnt=0010.
- **Clear and reset mid-pattern:**
  - ch0 sends 1,0,1, then clr[0]=1 for one cycle while req[0]=1 → gnt=0, bit dropped. ch0 then sends 0 → no flag.
  - Separately: ch0 sends 1,0,1, rst pulses, then ch0 sends 0 → no flag. ch0 then sends 1,0,1,0 → flag on the 4th bit.
- **Saturation:** CW=3, ch0 streams 1010 repeated for 10 matches → match_cnt reaches 7 and holds, while flag still pulses on every match.
